ov5642_pixel_packer: RTL and testbench



---
 rtl/ov5642_pixel_packer.sv | 157 +++++++++++++++
 tb/tb_ov5642_pixel_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5642_pixel_packer.sv
// OV5642 pixel packer: pairs capture bytes into RGB565 pixels, buffers them
// in a first-word-fall-through FIFO and presents them on a backpressured
// stream with line-end (tlast) and start-of-frame (tuser) marking.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_DISCARD  | input beats ignored until the next vsync rising edge
// ST_RUN      | bytes are paired into pixels and written to the FIFO
//
// An overflow drops the whole rest of the frame, so the sink never sees a
// torn frame that silently continues; it resynchronises on the next tuser.
module ov5642_pixel_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter bit BYTE_SWAP  = 1'b0
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_tdata,
  input  logic                          s_tlast,
  input  logic                          s_tvalid,
  input  logic                          vsync,
  output logic [15:0]                   m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic                          overflow,
  output logic                          align_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_DISCARD = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic            vsync_d;
  logic            frame_edge;
  logic            phase;
  logic [7:0]      hold;
  logic            sof_pending;

  logic            hold_load;
  logic            align_hit;
  logic            wr_req;
  logic            wr_ok;
  logic            wr_accept;
  logic            pop;
  logic [15:0]     pixel;

  logic [17:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [17:0]     head;

  assign frame_edge = vsync & ~vsync_d;
  assign pixel      = BYTE_SWAP ? {s_tdata, hold} : {hold, s_tdata};

  // A full FIFO can still take a write when the head leaves on the same edge.
  assign pop        = m_tvalid & m_tready;
  assign wr_ok      = (level != LW'(FIFO_DEPTH)) || pop;
  assign wr_accept  = wr_req & wr_ok;

  // Head entry is masked while empty so the outputs read zero after reset.
  assign head       = mem[rd_ptr];
  assign m_tvalid   = (level != '0);
  assign m_tdata    = m_tvalid ? head[17:2] : 16'h0000;
  assign m_tlast    = m_tvalid & head[1];
  assign m_tuser    = m_tvalid & head[0];
  assign fifo_level = level;

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DISCARD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-beat packing decisions; a frame edge wins over any beat.
  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    align_hit = 1'b0;
    wr_req    = 1'b0;
    if (frame_edge) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN && s_tvalid) begin
      if (!phase) begin
        if (s_tlast) begin
          align_hit = 1'b1;
        end else begin
          hold_load = 1'b1;
        end
      end else begin
        wr_req = 1'b1;
        if (!wr_ok) begin
          state_nxt = ST_DISCARD;
        end
      end
    end
  end

  // Pairing state, frame marking, error pulses and FIFO bookkeeping.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d     <= 1'b0;
      phase       <= 1'b0;
      hold        <= 8'h00;
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
      align_err   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      vsync_d   <= vsync;
      overflow  <= wr_req & ~wr_ok;
      align_err <= align_hit;
      if (frame_edge) begin
        phase       <= 1'b0;
        hold        <= 8'h00;
        sof_pending <= 1'b1;
      end else begin
        if (hold_load) begin
          hold  <= s_tdata;
          phase <= 1'b1;
        end
        if (wr_req) begin
          phase       <= 1'b0;
          sof_pending <= 1'b0;
        end
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(wr_accept) - LW'(pop);
    end
  end

  // Pixel storage; contents need no reset because reads are masked by level.
  always_ff @(posedge pclk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= {pixel, s_tlast, sof_pending};
    end
  end

endmodule

// File: tb/tb_ov5642_pixel_packer.sv
module tb_ov5642_pixel_packer;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        vsync = 1'b0;
  logic        m_tready = 1'b0;

  logic [15:0] m_tdata, m_tdata_s;
  logic        m_tvalid, m_tvalid_s;
  logic        m_tlast, m_tlast_s;
  logic        m_tuser, m_tuser_s;
  logic        overflow, overflow_s;
  logic        align_err, align_err_s;
  logic [4:0]  fifo_level, fifo_level_s;

  int checks = 0;
  int failures = 0;
  int ovf_seen = 0;

  ov5642_pixel_packer #(.FIFO_DEPTH(16), .BYTE_SWAP(1'b0)) dut (
    .pclk(pclk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .vsync(vsync), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .overflow(overflow), .align_err(align_err), .fifo_level(fifo_level)
  );

  ov5642_pixel_packer #(.FIFO_DEPTH(16), .BYTE_SWAP(1'b1)) dut_swap (
    .pclk(pclk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .vsync(vsync), .m_tdata(m_tdata_s), .m_tvalid(m_tvalid_s),
    .m_tready(m_tready), .m_tlast(m_tlast_s), .m_tuser(m_tuser_s),
    .overflow(overflow_s), .align_err(align_err_s), .fifo_level(fifo_level_s)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        vs;
    logic        tv;
    logic [7:0]  td;
    logic        tl;
    logic        ev;
    logic [15:0] ed;
    logic [15:0] es;
    logic        el;
    logic        eu;
    logic        ea;
    int          lvl;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic vs, input logic tv, input logic [7:0] td,
                              input logic tl, input logic ev, input logic [15:0] ed,
                              input logic [15:0] es, input logic el, input logic eu,
                              input logic ea, input int lvl);
    vec_t v;
    v.vs = vs; v.tv = tv; v.td = td; v.tl = tl; v.ev = ev; v.ed = ed;
    v.es = es; v.el = el; v.eu = eu; v.ea = ea; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    if (overflow === 1'b1) ovf_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; vsync = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    step();
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 0);
    chk({tag, " m_tdata"}, 32'(m_tdata), 0);
    chk({tag, " m_tlast"}, 32'(m_tlast), 0);
    chk({tag, " m_tuser"}, 32'(m_tuser), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " align_err"}, 32'(align_err), 0);
    chk({tag, " fifo_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    int n;

    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 8'h12, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 8'h34, 0, 1, 16'h1234, 16'h3412, 0, 1, 0, 1);
    tbl[3]  = mk(1, 1, 8'h56, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 8'h78, 1, 1, 16'h5678, 16'h7856, 1, 0, 0, 1);
    tbl[5]  = mk(1, 0, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 8'hA1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 8'hB2, 0, 1, 16'hA1B2, 16'hB2A1, 0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 8'hC3, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    tbl[9]  = mk(1, 1, 8'hD4, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 8'hE5, 1, 1, 16'hD4E5, 16'hE5D4, 1, 0, 0, 1);
    tbl[11] = mk(1, 0, 8'h00, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    // reset state while held in reset
    #1;
    chk_zero("reset");

    // basic packing, byte swap and odd-line alignment from the table
    do_reset();
    m_tready = 1'b1;
    idle();
    for (int i = 0; i < 12; i++) begin
      vsync = tbl[i].vs; s_tvalid = tbl[i].tv; s_tdata = tbl[i].td; s_tlast = tbl[i].tl;
      step();
      chk($sformatf("v%0d valid", i), 32'(m_tvalid), 32'(tbl[i].ev));
      chk($sformatf("v%0d level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d align_err", i), 32'(align_err), 32'(tbl[i].ea));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d data", i), 32'(m_tdata), 32'(tbl[i].ed));
        chk($sformatf("v%0d swap data", i), 32'(m_tdata_s), 32'(tbl[i].es));
        chk($sformatf("v%0d last", i), 32'(m_tlast), 32'(tbl[i].el));
        chk($sformatf("v%0d user", i), 32'(m_tuser), 32'(tbl[i].eu));
        chk($sformatf("v%0d swap user", i), 32'(m_tuser_s), 32'(tbl[i].eu));
      end
    end

    // no vsync edge after reset: nothing emitted
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(8'(8'h40 + i), logic'(i == 7));
      chk("novsync valid", 32'(m_tvalid), 0);
      chk("novsync level", 32'(fifo_level), 0);
    end
    idle();

    // overflow: 17 pixels into a stalled 16-deep FIFO
    do_reset();
    m_tready = 1'b0;
    idle();
    vsync = 1'b1;
    idle();
    ovf_seen = 0;
    for (int p = 0; p < 17; p++) begin
      beat(8'(2 * p), 1'b0);
      beat(8'(2 * p + 1), 1'b0);
      if (p == 15) chk("ovf level full", 32'(fifo_level), 16);
      if (p == 15) chk("ovf not yet", 32'(overflow), 0);
      if (p == 16) chk("ovf pulse", 32'(overflow), 1);
    end
    for (int i = 0; i < 4; i++) begin
      beat(8'(8'h80 + i), 1'b0);
      chk("ovf discard overflow", 32'(overflow), 0);
      chk("ovf discard level", 32'(fifo_level), 16);
    end
    idle();
    chk("ovf pulse count", 32'(ovf_seen), 1);
    m_tready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_tvalid) begin
        chk("drain data", 32'(m_tdata), 32'({8'(2 * n), 8'(2 * n + 1)}));
        chk("drain user", 32'(m_tuser), 32'(n == 0));
        n++;
      end
      idle();
    end
    chk("drain count", 32'(n), 16);
    chk("drain level", 32'(fifo_level), 0);
    vsync = 1'b0;
    idle();
    vsync = 1'b1;
    idle();
    beat(8'hAB, 1'b0);
    beat(8'hCD, 1'b1);
    chk("resync valid", 32'(m_tvalid), 1);
    chk("resync data", 32'(m_tdata), 32'h0000ABCD);
    chk("resync user", 32'(m_tuser), 1);
    chk("resync last", 32'(m_tlast), 1);
    idle();

    // asynchronous reset with 5 pixels buffered
    do_reset();
    m_tready = 1'b0;
    vsync = 1'b1;
    idle();
    for (int p = 0; p < 5; p++) begin
      beat(8'(8'h10 + 2 * p), 1'b0);
      beat(8'(8'h11 + 2 * p), 1'b0);
    end
    vsync = 1'b0;
    idle();
    chk("midrst level before", 32'(fifo_level), 5);
    chk("midrst valid before", 32'(m_tvalid), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat(8'(8'h60 + i), 1'b0);
      chk("postrst valid", 32'(m_tvalid), 0);
    end
    s_tvalid = 1'b0;
    vsync = 1'b1;
    idle();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    chk("postrst first valid", 32'(m_tvalid), 1);
    chk("postrst first data", 32'(m_tdata), 32'h00001122);
    chk("postrst first user", 32'(m_tuser), 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
